// File: rtl/enc_3_6_seq.sv
// Sequential greedy encoder from a binary value to a 9-bit Fibonacci-number-system codeword.
// One code bit is resolved per cycle, MSB first, against weights captured when the input is accepted.
module enc_3_6_seq #(
   parameter int BLEN_03   = 6,
   parameter int FNSLEN_03 = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BLEN_03-1:0]   in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FNSLEN_03-1:0] FNS03,
   input  logic [FNSLEN_03-1:0] FNS04,
   input  logic [FNSLEN_03-1:0] FNS05,
   input  logic [FNSLEN_03-1:0] FNS06,
   input  logic [FNSLEN_03-1:0] FNS07,
   input  logic [FNSLEN_03-1:0] FNS08,
   input  logic [FNSLEN_03-1:0] FNS09,
   output logic [8:0]           codeout,
   output logic [8:0]           en_flag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 err
);

   // state | meaning
   // IDLE  | waiting for an input; in_ready high once out of reset
   // CONV  | resolving code bit idx (8 down to 0), one bit per cycle
   // DONE  | result held on the outputs until out_ready

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [BLEN_03-1:0] LIMIT = BLEN_03'(54);

   state_t                     state, state_n;
   logic [BLEN_03-1:0]         r, r_n;
   logic [3:0]                 idx, idx_n;
   logic [8:0]                 code_n;
   logic                       err_n;
   logic [7*FNSLEN_03-1:0]     wts, wts_n;
   logic [BLEN_03-1:0]         w_sel;
   logic                       rdy;
   logic                       accept;

   // Bits 0 and 1 both weigh 1; higher bits come from the captured weight bank.
   always_comb begin
      w_sel = BLEN_03'(1);
      if (idx >= 4'd2 && idx <= 4'd8) begin
         w_sel = BLEN_03'(wts[(32'(idx) - 2) * FNSLEN_03 +: FNSLEN_03]);
      end
   end

   assign in_ready  = (state == IDLE) && rdy;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign en_flag   = (out_valid && !err) ? 9'h1FF : 9'h000;

   always_comb begin
      state_n = state;
      r_n     = r;
      idx_n   = idx;
      code_n  = codeout;
      err_n   = err;
      wts_n   = wts;
      case (state)
         IDLE: begin
            if (accept) begin
               r_n    = in_data;
               wts_n  = {FNS09, FNS08, FNS07, FNS06, FNS05, FNS04, FNS03};
               idx_n  = 4'd8;
               code_n = 9'h000;
               if (in_data > LIMIT) begin
                  err_n   = 1'b1;
                  state_n = DONE;
               end else begin
                  err_n   = 1'b0;
                  state_n = CONV;
               end
            end
         end
         CONV: begin
            if (r >= w_sel) begin
               code_n[idx] = 1'b1;
               r_n         = r - w_sel;
            end
            if (idx == 4'd0) begin
               state_n = DONE;
            end else begin
               idx_n = idx - 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_n = IDLE;
               code_n  = 9'h000;
               err_n   = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            code_n  = 9'h000;
            err_n   = 1'b0;
         end
      endcase
   end

   // rdy keeps in_ready low during reset and releases it on the first edge afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         r       <= '0;
         idx     <= 4'd8;
         codeout <= 9'h000;
         err     <= 1'b0;
         wts     <= '0;
         rdy     <= 1'b0;
      end else begin
         state   <= state_n;
         r       <= r_n;
         idx     <= idx_n;
         codeout <= code_n;
         err     <= err_n;
         wts     <= wts_n;
         rdy     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_enc_3_6_seq.sv
// Directed bench for enc_3_6_seq: vector table, handshake corners, reset abort and a full 0..54 sweep.
module tb_enc_3_6_seq;
   logic       clk;
   logic       rst_n;
   logic [5:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] fns03, fns04, fns05, fns06, fns07, fns08, fns09;
   logic [8:0] codeout;
   logic [8:0] en_flag;
   logic       out_valid;
   logic       out_ready;
   logic       err;

   int total = 0;
   int bad   = 0;
   int wt [9] = '{1, 1, 2, 3, 5, 8, 13, 21, 34};

   typedef struct {
      logic [5:0] data;
      logic [8:0] code;
      logic       e;
      logic       chg;
   } vec_t;

   vec_t vecs [13];

   enc_3_6_seq #(.BLEN_03(6), .FNSLEN_03(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .FNS03(fns03), .FNS04(fns04), .FNS05(fns05), .FNS06(fns06),
      .FNS07(fns07), .FNS08(fns08), .FNS09(fns09),
      .codeout(codeout), .en_flag(en_flag), .out_valid(out_valid),
      .out_ready(out_ready), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic nominal();
      fns03 = 6'd2; fns04 = 6'd3; fns05 = 6'd5; fns06 = 6'd8;
      fns07 = 6'd13; fns08 = 6'd21; fns09 = 6'd34;
   endtask

   task automatic accept(input logic [5:0] d);
      int n;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) check("done_timeout", 0, 1);
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, "_clr_valid"}, out_valid, 0);
      check({tag, "_clr_code"}, codeout, 0);
      check({tag, "_clr_en"}, en_flag, 0);
      check({tag, "_clr_err"}, err, 0);
      check({tag, "_clr_ready"}, in_ready, 1);
   endtask

   initial begin
      int lat;
      int dec;
      logic [8:0] held;

      vecs[0]  = '{6'd54, 9'h154, 1'b0, 1'b0};
      vecs[1]  = '{6'd20, 9'h054, 1'b0, 1'b0};
      vecs[2]  = '{6'd0,  9'h000, 1'b0, 1'b0};
      vecs[3]  = '{6'd55, 9'h000, 1'b1, 1'b0};
      vecs[4]  = '{6'd1,  9'h002, 1'b0, 1'b0};
      vecs[5]  = '{6'd2,  9'h004, 1'b0, 1'b0};
      vecs[6]  = '{6'd3,  9'h008, 1'b0, 1'b0};
      vecs[7]  = '{6'd4,  9'h00A, 1'b0, 1'b0};
      vecs[8]  = '{6'd7,  9'h014, 1'b0, 1'b0};
      vecs[9]  = '{6'd12, 9'h02A, 1'b0, 1'b0};
      vecs[10] = '{6'd33, 9'h0AA, 1'b0, 1'b0};
      vecs[11] = '{6'd63, 9'h000, 1'b1, 1'b0};
      vecs[12] = '{6'd54, 9'h154, 1'b0, 1'b1};

      nominal();
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      check("rst_ready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_code", codeout, 0);
      check("rst_en", en_flag, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_rel_ready_low", in_ready, 0);
      @(posedge clk);
      #1 check("rst_rel_ready_high", in_ready, 1);

      foreach (vecs[i]) begin
         accept(vecs[i].data);
         if (vecs[i].chg) begin
            fns03 = 6'd1; fns04 = 6'd1; fns05 = 6'd1; fns06 = 6'd1;
            fns07 = 6'd1; fns08 = 6'd1; fns09 = 6'd1;
         end
         wait_done(lat);
         check($sformatf("v%0d_latency", i), lat, vecs[i].e ? 1 : 10);
         check($sformatf("v%0d_code", i), codeout, vecs[i].code);
         check($sformatf("v%0d_err", i), err, vecs[i].e);
         check($sformatf("v%0d_en", i), en_flag, vecs[i].e ? 9'h000 : 9'h1FF);
         nominal();
         handoff($sformatf("v%0d", i));
      end

      // DONE held with out_ready low while upstream already presents the next value
      accept(6'd20);
      wait_done(lat);
      held = codeout;
      check("hold_first_code", held, 9'h054);
      @(negedge clk);
      in_data = 6'd33;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("hold_valid", out_valid, 1);
         check("hold_code", codeout, held);
         check("hold_en", en_flag, 9'h1FF);
         check("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("hold_handoff_valid", out_valid, 0);
      check("hold_handoff_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("hold_second_accepted", in_ready, 0);
      wait_done(lat);
      check("hold_second_latency", lat, 10);
      check("hold_second_code", codeout, 9'h0AA);
      handoff("hold2");

      // reset in the middle of a conversion
      accept(6'd54);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_code", codeout, 0);
      check("abort_en", en_flag, 0);
      check("abort_err", err, 0);
      check("abort_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1 check("abort_no_result", out_valid, 0);
      end
      accept(6'd33);
      wait_done(lat);
      check("abort_next_latency", lat, 10);
      check("abort_next_code", codeout, 9'h0AA);
      handoff("abort");

      // sweep every legal value through an FNS decoder
      for (int v = 0; v <= 54; v++) begin
         accept(6'(v));
         wait_done(lat);
         dec = 0;
         for (int b = 0; b < 9; b++) if (codeout[b]) dec += wt[b];
         check($sformatf("sweep%0d_decode", v), dec, v);
         check($sformatf("sweep%0d_adjacent", v),
               32'(codeout[8:1] & (codeout[8:1] >> 1)), 0);
         check($sformatf("sweep%0d_bit0", v), codeout[0], 0);
         check($sformatf("sweep%0d_err", v), err, 0);
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
